countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
- Countdown timer: the user presets minutes and seconds, starts the count, and the block decrements MM:SS.cc (centiseconds) to 00:00.00.
- At zero it halts and asserts alarm.
- Drop-in companion to the stopwatch top level, using the same buttons and 7-seg display style, but counting in the opposite direction.
- Uses one clock with an internal tick enable; no derived clocks.

Parameters:
- TICK_DIV, 500000: clk cycles per centisecond tick (50 MHz -> 100 Hz); legal range is 2 or more.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- start_stop  input  1  raw button; rising edge starts, pauses, resumes or acknowledges
- set_min  input  1  raw button; rising edge increments preset minutes (IDLE only)
- set_sec  input  1  raw button; rising edge increments preset seconds (IDLE only)
- clear  input  1  raw button; rising edge returns to IDLE
- m10,m1,s10,s1,cs10,cs1  output  7 each  7-seg digits for minutes, seconds and centiseconds
  - active-low
  - bit0=a … bit6=g
  - '0' encodes as 7'b1000000
- alarm  output  1  high while in DONE
- running  output  1  high while in RUN

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; min=sec=cs=0; preset=0; prescaler=0.
  - alarm=0, running=0, all digits show '0'.
  - Synchronizers cleared.
- Input conditioning:
  - Each button passes through a 2-FF synchronizer followed by a rising-edge detector, giving a 1-cycle pulse.
  - The action is registered at the 3rd rising clk edge after the input is first sampled high.
  - Holding a button produces one action only.
- Priority per cycle: clear > start_stop > set_min > set_sec. Only the highest pending pulse acts; the other pulses that cycle are dropped.
- Registers:
  - min 0..59, sec 0..59, cs 0..99, held as binary.
  - BCD split for display is combinational (tens = v/10, ones = v%10).
  - Display is combinational from the registers, so it updates with zero latency.
- States:
  - IDLE
    - set_min: min = (min==59) ? 0 : min+1.
    - set_sec: sec = (sec==59) ? 0 : sec+1.
    - cs is held at 0.
    - start_stop with min|sec != 0: preset<= {min,sec}, prescaler<=0, go to RUN.
    - start_stop with 00:00: ignored, stays in IDLE.
    - clear: min=sec=0.
  - RUN
    - running=1; prescaler increments every cycle.
    - When prescaler==TICK_DIV-1: prescaler<=0 and decrement:
      - cs>0: cs-1.
      - else sec>0: sec-1, cs=99.
      - else: min-1, sec=59, cs=99.
    - The decrement that yields 00:00.00 also sets state=DONE and alarm=1 on the same edge.
    - start_stop: go to PAUSE. If a tick coincides in that cycle, the pause wins and no decrement occurs.
    - set_min/set_sec are ignored.
    - clear: go to IDLE, load min/sec from preset, cs=0.
  - PAUSE
    - Count and prescaler are frozen, so resume keeps the fractional tick.
    - start_stop: go to RUN.
    - clear: go to IDLE, reload preset, cs=0.
    - set_min/set_sec are ignored.
  - DONE
    - alarm=1, count held at 00:00.00.
    - start_stop or clear: go to IDLE, reload preset, cs=0, alarm=0.
- Wrap/underflow: no decrement occurs outside RUN, so the count never goes below 00:00.00.
- Reset mid-RUN behaves as a full reset; the preset is lost.

Test Plan (TICK_DIV=4):
- Reset, release rst -> IDLE, all six digits 7'b1000000, alarm=0, running=0.
- Preset edit:
  - 2× set_min pulses -> min=2.
  - 60× set_sec pulses -> sec wraps back to 0.
  - set_sec held high for 100 cycles -> exactly +1.
- Preset 00:01, start_stop:
  - running=1.
  - First tick -> 00:00.99.
  - After 100 ticks (400 cycles) -> 00:00.00 with alarm=1 on the same edge, running=0.
  - Count stays at zero afterwards.
- Preset 01:00, run 1 tick -> 00:59.99 (borrow across min/sec/cs). Then:
  - start_stop -> PAUSE; display frozen for 50 cycles.
  - start_stop -> resume with no lost prescaler phase.
  - clear -> IDLE showing 01:00.00.
- start_stop and set_min pulsed in the same cycle in IDLE with 00:05 -> enters RUN; min unchanged.
- start_stop pulsed from 00:00 in IDLE -> stays IDLE.
- Async rst asserted mid-RUN, between clock edges -> outputs reset immediately; preset=0.

Source files
------------

// File: rtl/countdown_timer.sv
// countdown_timer
//   Presettable MM:SS countdown with centisecond resolution. The user edits
//   minutes/seconds in IDLE, starts the count, may pause/resume, and the block
//   decrements MM:SS.cc down to 00:00.00, where it halts and raises alarm.
//   A single clock is used; a prescaler produces a centisecond tick enable.
//
// Ports
//   clk         system clock
//   rst         asynchronous reset, active low
//   start_stop  raw button: start / pause / resume / acknowledge alarm
//   set_min     raw button: increment preset minutes (IDLE only)
//   set_sec     raw button: increment preset seconds (IDLE only)
//   clear       raw button: return to IDLE (zeroes the preset while in IDLE)
//   m10..cs1    active-low 7-seg digits (bit0=a .. bit6=g)
//   alarm       high while the count has expired
//   running     high while counting
module countdown_timer #(
    parameter int TICK_DIV = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_stop,
    input  logic       set_min,
    input  logic       set_sec,
    input  logic       clear,
    output logic [6:0] m10,
    output logic [6:0] m1,
    output logic [6:0] s10,
    output logic [6:0] s1,
    output logic [6:0] cs10,
    output logic [6:0] cs1,
    output logic       alarm,
    output logic       running
);

    localparam int PW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Active-low 7-seg pattern for one decimal digit; blank for non-digits.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] hi;
        case (d)
            4'd0:    hi = 7'h3F;
            4'd1:    hi = 7'h06;
            4'd2:    hi = 7'h5B;
            4'd3:    hi = 7'h4F;
            4'd4:    hi = 7'h66;
            4'd5:    hi = 7'h6D;
            4'd6:    hi = 7'h7D;
            4'd7:    hi = 7'h07;
            4'd8:    hi = 7'h7F;
            4'd9:    hi = 7'h6F;
            default: hi = 7'h00;
        endcase
        return ~hi;
    endfunction

    function automatic logic [3:0] tens(input logic [6:0] v);
        return 4'(v / 7'd10);
    endfunction

    function automatic logic [3:0] ones(input logic [6:0] v);
        return 4'(v % 7'd10);
    endfunction

    // Button conditioning: 2-FF synchronizer plus rising-edge detect.
    // Bit order: [0]=clear, [1]=start_stop, [2]=set_min, [3]=set_sec.
    logic [3:0] sync1_q, sync2_q, prev_q;
    logic [3:0] pulse;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= {set_sec, set_min, start_stop, clear};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign pulse = sync2_q & ~prev_q;

    logic clr_p, ss_p, smin_p, ssec_p;
    assign clr_p  = pulse[0];
    assign ss_p   = pulse[1];
    assign smin_p = pulse[2];
    assign ssec_p = pulse[3];

    // Timer state and count registers
    state_t        state_q, state_d;
    logic [5:0]    min_q, min_d;
    logic [5:0]    sec_q, sec_d;
    logic [6:0]    cs_q, cs_d;
    logic [5:0]    pmin_q, pmin_d;
    logic [5:0]    psec_q, psec_d;
    logic [PW-1:0] presc_q, presc_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            min_q   <= '0;
            sec_q   <= '0;
            cs_q    <= '0;
            pmin_q  <= '0;
            psec_q  <= '0;
            presc_q <= '0;
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            cs_q    <= cs_d;
            pmin_q  <= pmin_d;
            psec_q  <= psec_d;
            presc_q <= presc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        sec_d   = sec_q;
        cs_d    = cs_q;
        pmin_d  = pmin_q;
        psec_d  = psec_q;
        presc_d = presc_q;

        case (state_q)
            S_IDLE: begin
                cs_d = '0;
                if (clr_p) begin
                    min_d = '0;
                    sec_d = '0;
                end else if (ss_p) begin
                    // A 00:00 preset would expire immediately; ignore the start.
                    if (min_q != 6'd0 || sec_q != 6'd0) begin
                        pmin_d  = min_q;
                        psec_d  = sec_q;
                        presc_d = '0;
                        state_d = S_RUN;
                    end
                end else if (smin_p) begin
                    min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
                end else if (ssec_p) begin
                    sec_d = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
                end
            end

            S_RUN: begin
                if (clr_p) begin
                    state_d = S_IDLE;
                    min_d   = pmin_q;
                    sec_d   = psec_q;
                    cs_d    = '0;
                end else if (ss_p) begin
                    // Pause freezes the prescaler too, even on a tick cycle,
                    // so the pending tick is delivered right after resume.
                    state_d = S_PAUSE;
                end else if (presc_q == PW'(TICK_DIV - 1)) begin
                    presc_d = '0;
                    if (cs_q != 7'd0) begin
                        cs_d = cs_q - 7'd1;
                    end else if (sec_q != 6'd0) begin
                        sec_d = sec_q - 6'd1;
                        cs_d  = 7'd99;
                    end else begin
                        min_d = min_q - 6'd1;
                        sec_d = 6'd59;
                        cs_d  = 7'd99;
                    end
                    // Only the .01 -> .00 step can land on zero.
                    if (min_q == 6'd0 && sec_q == 6'd0 && cs_q == 7'd1) begin
                        state_d = S_DONE;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end

            S_PAUSE: begin
                if (clr_p) begin
                    state_d = S_IDLE;
                    min_d   = pmin_q;
                    sec_d   = psec_q;
                    cs_d    = '0;
                end else if (ss_p) begin
                    state_d = S_RUN;
                end
            end

            S_DONE: begin
                if (clr_p || ss_p) begin
                    state_d = S_IDLE;
                    min_d   = pmin_q;
                    sec_d   = psec_q;
                    cs_d    = '0;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign alarm   = (state_q == S_DONE);
    assign running = (state_q == S_RUN);

    assign m10  = seg7(tens({1'b0, min_q}));
    assign m1   = seg7(ones({1'b0, min_q}));
    assign s10  = seg7(tens({1'b0, sec_q}));
    assign s1   = seg7(ones({1'b0, sec_q}));
    assign cs10 = seg7(tens(cs_q));
    assign cs1  = seg7(ones(cs_q));

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer (TICK_DIV=4): directed scenarios followed by
// randomized button activity, every cycle checked against a time-based model
// that tracks remaining centiseconds as a single integer.
module tb_countdown_timer;

    localparam int TD = 4;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic clk;
    logic rst;
    logic [3:0] btn;  // [0]=clear [1]=start_stop [2]=set_min [3]=set_sec
    logic [6:0] m10, m1, s10, s1, cs10, cs1;
    logic alarm, running;

    countdown_timer #(.TICK_DIV(TD)) dut (
        .clk(clk),
        .rst(rst),
        .start_stop(btn[1]),
        .set_min(btn[2]),
        .set_sec(btn[3]),
        .clear(btn[0]),
        .m10(m10),
        .m1(m1),
        .s10(s10),
        .s1(s1),
        .cs10(cs10),
        .cs1(cs1),
        .alarm(alarm),
        .running(running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Active-low 7-seg patterns (g..a), written out digit by digit.
    logic [6:0] SEG [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000};

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model
    int mode, emin, esec, pmin, psec, rem, phase;
    logic [3:0] h1, h2, h3;  // button samples from the last three edges

    function automatic void model_reset();
        mode = M_IDLE; emin = 0; esec = 0; pmin = 0; psec = 0; rem = 0; phase = 0;
        h1 = '0; h2 = '0; h3 = '0;
    endfunction

    function automatic void model_edge(input logic [3:0] r);
        logic [3:0] pl;
        // An action lands on the third edge after a button is first seen high.
        pl = h2 & ~h3;
        h3 = h2; h2 = h1; h1 = r;
        if (pl[0]) begin
            if (mode == M_IDLE) begin
                emin = 0; esec = 0;
            end else begin
                mode = M_IDLE; emin = pmin; esec = psec;
            end
        end else if (pl[1]) begin
            case (mode)
                M_IDLE: if (emin != 0 || esec != 0) begin
                    pmin = emin; psec = esec;
                    rem = emin * 6000 + esec * 100;
                    phase = 0; mode = M_RUN;
                end
                M_RUN:   mode = M_PAUSE;
                M_PAUSE: mode = M_RUN;
                default: begin mode = M_IDLE; emin = pmin; esec = psec; end
            endcase
        end else if (mode == M_IDLE) begin
            if (pl[2]) emin = (emin + 1) % 60;
            else if (pl[3]) esec = (esec + 1) % 60;
        end else if (mode == M_RUN) begin
            phase++;
            if (phase == TD) begin
                phase = 0;
                rem--;
                if (rem == 0) mode = M_DONE;
            end
        end
    endfunction

    function automatic logic [41:0] exp_disp();
        int t, m, s, c;
        t = (mode == M_IDLE) ? (emin * 6000 + esec * 100) : rem;
        m = t / 6000;
        s = (t / 100) % 60;
        c = t % 100;
        return {SEG[m / 10], SEG[m % 10], SEG[s / 10], SEG[s % 10], SEG[c / 10], SEG[c % 10]};
    endfunction

    function automatic logic [41:0] disp();
        return {m10, m1, s10, s1, cs10, cs1};
    endfunction

    task automatic compare_all();
        chk("disp",    64'(disp()),  64'(exp_disp()));
        chk("alarm",   64'(alarm),   64'(mode == M_DONE));
        chk("running", 64'(running), 64'(mode == M_RUN));
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) model_reset();
        else model_edge(btn);
        #1;
        compare_all();
    endtask

    task automatic press(input int b, input int hold);
        btn[b] = 1'b1;
        repeat (hold) step();
        btn[b] = 1'b0;
        repeat (3) step();
    endtask

    logic [41:0] zero_disp;
    int n;

    initial begin
        zero_disp = {6{7'b1000000}};
        rst = 1'b0;
        btn = '0;
        model_reset();
        #2;
        chk("rst_async_disp", 64'(disp()), 64'(zero_disp));
        repeat (2) step();
        rst = 1'b1;
        chk("rst_disp", 64'(disp()), 64'(zero_disp));
        chk("rst_alarm", 64'(alarm), 64'd0);
        chk("rst_running", 64'(running), 64'd0);

        // Preset editing
        press(2, 1);
        press(2, 1);
        chk("min_two", 64'({m10, m1}), 64'({7'b1000000, 7'b0100100}));
        repeat (60) press(3, 1);
        chk("sec_wrap", 64'({s10, s1}), 64'({7'b1000000, 7'b1000000}));
        btn[3] = 1'b1;
        repeat (100) step();
        btn[3] = 1'b0;
        repeat (3) step();
        chk("sec_hold_once", 64'({s10, s1}), 64'({7'b1000000, 7'b1111001}));

        // 00:01 countdown to alarm
        press(0, 1);
        press(3, 1);
        press(1, 1);
        chk("run_started", 64'(running), 64'd1);
        repeat (410) step();
        chk("done_alarm", 64'(alarm), 64'd1);
        chk("done_disp", 64'(disp()), 64'(zero_disp));
        chk("done_not_running", 64'(running), 64'd0);
        repeat (20) step();
        chk("done_held", 64'(disp()), 64'(zero_disp));

        // 01:00 borrow, pause/resume, clear reload
        press(1, 1);
        press(0, 1);
        press(2, 1);
        press(1, 1);
        repeat (3) step();
        chk("borrow", 64'(disp()),
            64'({SEG[0], SEG[0], SEG[5], SEG[9], SEG[9], SEG[9]}));
        repeat (2) step();
        press(1, 1);
        repeat (50) step();
        press(1, 1);
        repeat (9) step();
        press(0, 1);
        chk("clear_reload", 64'(disp()),
            64'({SEG[0], SEG[1], SEG[0], SEG[0], SEG[0], SEG[0]}));

        // start_stop and set_min in the same cycle from 00:05
        press(0, 1);
        repeat (5) press(3, 1);
        btn = 4'b0110;
        step();
        btn = '0;
        repeat (3) step();
        chk("simul_running", 64'(running), 64'd1);
        chk("simul_min", 64'({m10, m1}), 64'({7'b1000000, 7'b1000000}));
        press(0, 1);

        // start from 00:00 is ignored
        press(0, 1);
        press(1, 1);
        chk("zero_start_idle", 64'(running), 64'd0);

        // Asynchronous reset mid-run
        press(3, 1);
        press(1, 1);
        repeat (30) step();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("arst_running", 64'(running), 64'd0);
        chk("arst_disp", 64'(disp()), 64'(zero_disp));
        repeat (3) step();
        #2;
        rst = 1'b1;
        repeat (2) step();
        press(1, 1);
        chk("arst_preset_lost", 64'(running), 64'd0);

        // Randomized rounds: short preset, random button activity while counting
        for (int r = 0; r < 6; r++) begin
            press(0, 1);
            n = $urandom_range(1, 3);
            repeat (n) press(3, 1);
            press(1, 1);
            for (int i = 0; i < n * 400 + 200; i++) begin
                btn[0] = ($urandom_range(0, 799) == 0);
                btn[1] = ($urandom_range(0, 99) == 0);
                btn[2] = ($urandom_range(0, 149) == 0);
                btn[3] = ($urandom_range(0, 149) == 0);
                step();
            end
            btn = '0;
            repeat (4) step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
